// File: rtl/lsu_pkg.sv
// Shared types for the load/store split unit: access size, FSM state and size decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE  = 2'd0,
    LSU_HALF  = 2'd1,
    LSU_WORD  = 2'd2,
    LSU_DWORD = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ2,
    WAIT2,
    RESP
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(lsu_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store-data rotate, byte-enable generation and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  lsu_size_e                  size,
  input  logic                       sign,
  input  logic [DATA_W-1:0]          beat_lo,
  input  logic [DATA_W-1:0]          beat_hi,
  output logic [DATA_W-1:0]          wdata_rot,
  output logic [DATA_W/8-1:0]        mask_lo,
  output logic [DATA_W/8-1:0]        mask_hi,
  output logic [DATA_W-1:0]          rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W+2:0]    shamt;
  logic [2*DATA_W-1:0] rot_wide;
  logic [2*DATA_W-1:0] rd_wide;
  logic [2*NB-1:0]     full;
  logic [DATA_W-1:0]   shifted;
  logic [6:0]          nbits;
  logic                msb;

  assign shamt = {offset, 3'b000};

  // Rotate via a doubled word: the upper half of the shifted pair is the rotated value.
  assign rot_wide  = {wdata, wdata} << shamt;
  assign wdata_rot = rot_wide[2*DATA_W-1:DATA_W];

  assign full    = (((2*NB)'(1) << size_bytes(size)) - (2*NB)'(1)) << offset;
  assign mask_lo = full[NB-1:0];
  assign mask_hi = full[2*NB-1:NB];

  assign rd_wide = {beat_hi, beat_lo} >> shamt;
  assign shifted = rd_wide[DATA_W-1:0];
  assign nbits   = {size_bytes(size), 3'b000};

  always_comb begin
    msb   = 1'b0;
    rdata = '0;
    case (size)
      LSU_BYTE: msb = shifted[7];
      LSU_HALF: msb = shifted[15];
      LSU_WORD: msb = shifted[31];
      default:  msb = shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      rdata[i] = (i < int'(nbits)) ? shifted[i] : (sign & msb);
    end
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit that splits misaligned accesses into two memory beats when LSU_SPLIT_MISALIGN_EN is defined.
// States: IDLE accept request | REQ1/REQ2 issue beat | WAIT1/WAIT2 await beat response | RESP one-cycle completion
module lsu_split
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

`ifdef LSU_SPLIT_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  lsu_size_e         size_q;
  logic              sign_q, write_q, split_q, err_q;

  logic [OFF_W-1:0]  req_off, off_q;
  logic [4:0]        req_end;
  logic              req_split, req_big, req_fault;
  logic [DATA_W-1:0] beat_lo, beat_hi, wdata_rot, ext_rdata;
  logic [NB-1:0]     mask_lo, mask_hi;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_end   = 5'(req_off) + 5'(size_bytes(lsu_size_e'(req_size)));
  assign req_split = req_end > 5'(NB);
  assign req_big   = size_bytes(lsu_size_e'(req_size)) > 4'(NB);
  assign req_fault = req_big || (req_split && !SPLIT_EN);
  assign off_q     = addr_q[OFF_W-1:0];

`ifdef LSU_SPLIT_MISALIGN_EN
  logic [DATA_W-1:0] beat1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  beat1_q <= '0;
    else if (state_q == WAIT1 && mem_resp_valid) beat1_q <= mem_rdata;
  end

  assign beat_lo = (state_q == WAIT2) ? beat1_q : mem_rdata;
  assign beat_hi = (state_q == WAIT2) ? mem_rdata : '0;
`else
  assign beat_lo = mem_rdata;
  assign beat_hi = '0;
`endif

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .wdata     (wdata_q),
    .offset    (off_q),
    .size      (size_q),
    .sign      (sign_q),
    .beat_lo   (beat_lo),
    .beat_hi   (beat_hi),
    .wdata_rot (wdata_rot),
    .mask_lo   (mask_lo),
    .mask_hi   (mask_hi),
    .rdata     (ext_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = req_fault ? RESP : REQ1;
      REQ1:  if (mem_req_ready) state_d = WAIT1;
      WAIT1: if (mem_resp_valid) begin
               if (mem_resp_err)          state_d = RESP;
               else if (split_q && SPLIT_EN) state_d = REQ2;
               else                       state_d = RESP;
             end
      REQ2:  if (mem_req_ready) state_d = WAIT2;
      WAIT2: if (mem_resp_valid) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= LSU_BYTE;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= lsu_size_e'(req_size);
          sign_q  <= req_sign;
          write_q <= req_write;
          split_q <= req_split;
          err_q   <= req_fault;
          rdata_q <= '0;
        end
        WAIT1: if (mem_resp_valid) begin
          err_q <= mem_resp_err;
          if (!write_q) rdata_q <= ext_rdata;
        end
        WAIT2: if (mem_resp_valid) begin
          err_q <= err_q | mem_resp_err;
          if (!write_q) rdata_q <= ext_rdata;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_err      = resp_valid & err_q;
  assign resp_rdata    = rdata_q;
  assign mem_req_valid = (state_q == REQ1) || (state_q == REQ2);
  assign mem_write     = write_q;
  assign mem_addr      = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)}
                       + ((state_q == REQ2) ? ADDR_W'(NB) : '0);
  assign mem_wdata     = wdata_rot;
  // Byte enables only while a beat is offered so the idle bus stays quiet.
  assign mem_wmask     = (state_q == REQ1) ? mask_lo :
                         (state_q == REQ2) ? mask_hi : '0;

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split at DATA_W=32; split cases follow LSU_SPLIT_MISALIGN_EN.
module tb_lsu_split;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_write, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_err;

  int n_checks = 0;
  int n_errors = 0;

  int          t_lat, t_nb;
  logic [31:0] t_rdata;
  logic        t_err;
  logic [31:0] b_addr  [0:1];
  logic [31:0] b_wdata [0:1];
  logic [3:0]  b_mask  [0:1];
  logic        b_write [0:1];

  lsu_split #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_size       (req_size),
    .req_sign       (req_sign),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_mem_wmask"}, mem_wmask, 4'h0);
  endtask

  // Zero-wait memory: accept every beat, answer in the following cycle.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic e1);
    logic acc;
    acc = 1'b0; t_lat = -1; t_nb = 0; t_rdata = '0; t_err = 1'b0;
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    req_size = sz; req_sign = sg;
    @(negedge clock);
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
    req_size = ~sz; req_sign = ~sg;
    for (int c = 1; c <= 12 && t_lat < 0; c++) begin
      if (c > 1) @(negedge clock);
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = '0;
      if (acc) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = (t_nb == 1) ? rd1 : rd2;
        mem_resp_err   = (t_nb == 1) && e1;
        acc = 1'b0;
      end
      if (mem_req_valid) begin
        if (t_nb < 2) begin
          b_addr[t_nb] = mem_addr; b_wdata[t_nb] = mem_wdata;
          b_mask[t_nb] = mem_wmask; b_write[t_nb] = mem_write;
        end
        t_nb++;
        acc = 1'b1;
      end
      if (resp_valid) begin
        t_lat = c; t_rdata = resp_rdata; t_err = resp_err;
      end
    end
    chk("resp_seen", t_lat >= 0, 1'b1);
    @(negedge clock);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    chk("resp_one_cycle", resp_valid, 1'b0);
  endtask

  task automatic expect1(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] mask, input logic wr, input logic [31:0] rdata);
    chk({tag, "_lat"}, t_lat, 3);
    chk({tag, "_beats"}, t_nb, 1);
    chk({tag, "_addr"}, b_addr[0], addr);
    chk({tag, "_wdata"}, b_wdata[0], wd);
    chk({tag, "_mask"}, b_mask[0], mask);
    chk({tag, "_write"}, b_write[0], wr);
    chk({tag, "_rdata"}, t_rdata, rdata);
    chk({tag, "_err"}, t_err, 1'b0);
  endtask

  task automatic expect_err(input string tag, input int lat, input int nb);
    chk({tag, "_lat"}, t_lat, lat);
    chk({tag, "_beats"}, t_nb, nb);
    chk({tag, "_err"}, t_err, 1'b1);
  endtask

`ifdef LSU_SPLIT_MISALIGN_EN
  task automatic expect2(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] wd, input logic [3:0] m0, input logic [3:0] m1,
                         input logic [31:0] rdata);
    chk({tag, "_lat"}, t_lat, 5);
    chk({tag, "_beats"}, t_nb, 2);
    chk({tag, "_addr0"}, b_addr[0], a0);
    chk({tag, "_addr1"}, b_addr[1], a1);
    chk({tag, "_wdata0"}, b_wdata[0], wd);
    chk({tag, "_wdata1"}, b_wdata[1], wd);
    chk({tag, "_mask0"}, b_mask[0], m0);
    chk({tag, "_mask1"}, b_mask[1], m1);
    chk({tag, "_rdata"}, t_rdata, rdata);
    chk({tag, "_err"}, t_err, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_sign = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;

    repeat (2) @(negedge clock);
    chk_quiet("rst");
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk_quiet("post_rst");

    run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    expect1("lw_aligned", 32'h100, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF);
    run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80000000, 32'h0, 1'b0);
    expect1("lb_sext", 32'h100, 32'h0, 4'b1000, 1'b0, 32'hFFFFFF80);
    run_txn(1'b0, 32'h102, 32'h0, 2'd0, 1'b0, 32'h12AB3456, 32'h0, 1'b0);
    expect1("lbu_zext", 32'h100, 32'h0, 4'b0100, 1'b0, 32'h000000AB);
    run_txn(1'b0, 32'h106, 32'h0, 2'd1, 1'b1, 32'h80010000, 32'h0, 1'b0);
    expect1("lh_sext", 32'h104, 32'h0, 4'b1100, 1'b0, 32'hFFFF8001);
    run_txn(1'b0, 32'h100, 32'h0, 2'd1, 1'b0, 32'h1234F00D, 32'h0, 1'b0);
    expect1("lhu_zext", 32'h100, 32'h0, 4'b0011, 1'b0, 32'h0000F00D);
    run_txn(1'b1, 32'h104, 32'h11223344, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0);
    expect1("sw_aligned", 32'h104, 32'h11223344, 4'b1111, 1'b1, 32'h0);
    run_txn(1'b1, 32'h101, 32'hCAFE00A5, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0);
    expect1("sb_rot8", 32'h100, 32'hFE00A5CA, 4'b0010, 1'b1, 32'h0);
    run_txn(1'b1, 32'h10A, 32'h0000BEEF, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0);
    expect1("sh_rot16", 32'h108, 32'hBEEF0000, 4'b1100, 1'b1, 32'h0);
    run_txn(1'b0, 32'h108, 32'h0, 2'd2, 1'b0, 32'h55555555, 32'h0, 1'b1);
    expect_err("lw_beat_err", 3, 1);

`ifdef LSU_SPLIT_MISALIGN_EN
    run_txn(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, 32'h80112233, 32'h445566FF, 1'b0);
    expect2("lh_split", 32'h100, 32'h104, 32'h0, 4'b1000, 4'b0001, 32'hFFFFFF80);
    run_txn(1'b1, 32'h102, 32'h11223344, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    expect2("sw_split", 32'h100, 32'h104, 32'h33441122, 4'b1100, 4'b0011, 32'h0);
    run_txn(1'b0, 32'hFFFFFFFE, 32'h0, 2'd2, 1'b0, 32'h33440000, 32'h00001122, 1'b0);
    expect2("lw_wrap", 32'hFFFFFFFC, 32'h00000000, 32'h0, 4'b1100, 4'b0011, 32'h11223344);
    run_txn(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    expect_err("split_beat1_err", 3, 1);
`else
    run_txn(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_err("lw_split_off", 1, 0);
    run_txn(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, 32'h0, 32'h0, 1'b0);
    expect_err("lh_split_off", 1, 0);
    run_txn(1'b1, 32'h102, 32'h11223344, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_err("sw_split_off", 1, 0);
`endif
    run_txn(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_err("dword_too_big", 1, 0);

    // Abandon a load while it waits for its beat, then offer a stale response.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200; req_size = 2'd2; req_sign = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    chk("mid_req1_valid", mem_req_valid, 1'b1);
    @(negedge clock);
    chk("mid_wait1_valid", mem_req_valid, 1'b0);
    chk("mid_wait1_ready", req_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk_quiet("mid_rst");
    @(negedge clock);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem_resp_valid = 1'b0;
      chk_quiet("late_resp");
    end

    run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hA5A55A5A, 32'h0, 1'b0);
    expect1("lw_after_rst", 32'h100, 32'h0, 4'b1111, 1'b0, 32'hA5A55A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits, legal values 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the width of the byte address.
REQ-003 The block SHALL use reset reset, asynchronous, active-high, and clock clock.
REQ-004 Ports SHALL be, in this order:
- clock  in  1  clock
- reset  in  1  async active-high reset
- req_valid  in  1  core request
- req_ready  out  1  block can accept a request
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-justified
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_sign  in  1  sign-extend load
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data
- resp_err  out  1  access fault, qualified by resp_valid
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts
- mem_write  out  1  store beat
- mem_addr  out  ADDR_W  beat-aligned address
- mem_wdata  out  DATA_W  lane-rotated data
- mem_wmask  out  DATA_W/8  byte enables
- mem_resp_valid  in  1  beat response
- mem_rdata  in  DATA_W  beat read data
- mem_resp_err  in  1  beat error

Function
REQ-005 The FSM states SHALL be IDLE, REQ1, WAIT1, REQ2, WAIT2 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 A req_valid&&req_ready handshake SHALL register all request fields; later changes to the req_* inputs SHALL be ignored until the next IDLE.
REQ-007 From IDLE, a handshake SHALL go to RESP with the error flag set if (a) size bytes > DATA_W/8, or (b) the access is split and the split feature is disabled; otherwise it SHALL go to REQ1.
REQ-008 An access is split when offset + size_bytes > DATA_W/8, where offset = addr mod DATA_W/8.
REQ-009 In REQ1 and REQ2, mem_req_valid SHALL be held high with stable payload until mem_req_ready; on handshake the FSM SHALL go to WAIT1 or WAIT2 respectively.
REQ-010 In WAIT1, on mem_resp_valid:
- if mem_resp_err: go to RESP with the error flag set and issue no second beat;
- else if split: store beat 1 data and go to REQ2;
- else: go to RESP.
REQ-011 In WAIT2, on mem_resp_valid the FSM SHALL go to RESP, and the error flag SHALL be the OR of the beat errors.
REQ-012 In RESP, resp_valid SHALL be 1 for exactly one cycle; the FSM then returns to IDLE. There is no back-pressure on the response.
REQ-013 mem_addr SHALL be the registered address with the low log2(DATA_W/8) bits cleared; in REQ2 it SHALL be that value plus DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-014 mem_wdata SHALL be req_wdata rotated left by offset*8 bits in both beats.
REQ-015 mem_wmask SHALL be derived from full = ((1<<size_bytes)-1)<<offset: the low DATA_W/8 bits in beat 1 and the overflow bits in beat 2.
REQ-016 Load data SHALL be {beat2, beat1} shifted right by offset*8, truncated to size, then sign-extended if req_sign, else zero-extended.
REQ-017 mem_write SHALL equal the registered req_write.
REQ-018 For stores, resp_rdata SHALL be 0.
REQ-019 When there is no error, latency from the request handshake to resp_valid SHALL be 3 cycles for an unsplit access and 5 cycles for a split access, with zero-wait memory.
REQ-020 mem_resp_valid SHALL be ignored outside WAIT1 and WAIT2.

Reset
REQ-021 Reset SHALL force state IDLE and clear all registers.
REQ-022 During and after reset: req_ready=1, and resp_valid, resp_err, resp_rdata, mem_req_valid, mem_write, mem_addr, mem_wdata and mem_wmask SHALL all be 0.
REQ-023 Reset in any state SHALL abandon the transaction without producing resp_valid.

Configuration
REQ-024 The macro LSU_SPLIT_MISALIGN_EN SHALL control two-beat splitting.
- Defined: split accesses are performed per REQ-008 to REQ-016.
- Undefined: split accesses complete with resp_err=1 and no memory traffic, REQ2 and WAIT2 are unreachable, and beat-2 storage is not synthesised.

Structure
REQ-025 Package lsu_pkg SHALL hold the size enum (LSU_BYTE, LSU_HALF, LSU_WORD, LSU_DWORD), the FSM state enum, and a size-to-bytes function.
REQ-026 The combinational sub-module lsu_align, parametrised by DATA_W, SHALL perform the write rotate, mask generation and read extract/extend.

Verification (DATA_W=32)
REQ-027 Aligned load: lw at 0x100 with mem_rdata=0xDEADBEEF and zero-wait memory -> one beat with addr 0x100 and mask 4'b1111; resp_rdata=0xDEADBEEF, resp_err=0, 3 cycles after the handshake.
REQ-028 Split signed load: lh at 0x103 with beats 0x80xxxxxx at 0x100 and 0xxxxxxxFF at 0x104 -> masks 4'b1000 then 4'b0001; resp_rdata=0xFFFFFF80.
REQ-029 Split store: sw at 0x102 with wdata 0x11223344 -> beat 1 addr 0x100, wdata 0x33441122, mask 4'b1100; beat 2 addr 0x104, same wdata, mask 4'b0011.
REQ-030 First-beat error: split lw at 0x101 with mem_resp_err=1 on beat 1 -> no second mem_req_valid; resp_valid=1 with resp_err=1.
REQ-031 Split disabled: with the macro undefined, lw at 0x101 -> no mem_req_valid; resp_err=1 on the cycle after the handshake. Dword request at DATA_W=32 -> resp_err=1.
REQ-032 Reset mid-transaction: reset asserted in WAIT1 -> no resp_valid; req_ready=1 after release; a late mem_resp_valid is ignored.
